// File: rtl/cdc_handshake_tx_controller_pkg.sv
// -----------------------------------------------------------------------------
// cdc_handshake_tx_controller_pkg
// Shared definitions for the four-phase req/ack source-side handshake:
//   hs_state_e          - handshake FSM state (IDLE, REQ_HI, REQ_LO), 2-bit
//   hs_min_latency()    - minimum accept-to-done latency for a given number
//                         of ack synchronizer stages (zero-delay destination)
// -----------------------------------------------------------------------------
package cdc_handshake_tx_controller_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    REQ_HI = 2'b01,
    REQ_LO = 2'b10
  } hs_state_e;

  // The ack must cross the synchronizer twice (rise and fall), and each
  // phase needs one more edge for the FSM to act on the synchronized value.
  function automatic int unsigned hs_min_latency(input int unsigned sync_stages);
    return 2 * sync_stages + 2;
  endfunction

endpackage

// File: rtl/cdc_handshake_tx_controller_if.sv
// -----------------------------------------------------------------------------
// cdc_handshake_tx_controller_if
// Bundles the word-input handshake and the cross-domain req/ack bus.
//   in_valid/in_ready/in_data   - source-side word offer
//   xfer_req/xfer_data          - request and stable data to the destination
//   xfer_ack                    - asynchronous ack from the destination
//   busy/done/timeout_err       - status
// Modports: master = controller side, slave = user/destination side.
// -----------------------------------------------------------------------------
interface cdc_handshake_tx_controller_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  xfer_req;
  logic [DATA_WIDTH-1:0] xfer_data;
  logic                  xfer_ack;
  logic                  busy;
  logic                  done;
  logic                  timeout_err;

  modport master (
    input  in_valid, in_data, xfer_ack,
    output in_ready, xfer_req, xfer_data, busy, done, timeout_err
  );

  modport slave (
    output in_valid, in_data, xfer_ack,
    input  in_ready, xfer_req, xfer_data, busy, done, timeout_err
  );
endinterface

// File: rtl/double_flop_synchronizer.sv
// -----------------------------------------------------------------------------
// double_flop_synchronizer
// Two-flop single-bit synchronizer with clock enable.
//   clk, rst        - destination clock, active-high reset
//   i_en            - clock enable; low holds both flops
//   i_d / o_q       - asynchronous input / synchronized output
// AT_POSEDGE_RST: nonzero selects asynchronous reset, zero synchronous reset.
// -----------------------------------------------------------------------------
module double_flop_synchronizer #(
  parameter int unsigned AT_POSEDGE_RST = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_d,
  output logic o_q
);
  logic [1:0] r_sync;

  if (AT_POSEDGE_RST != 0) begin : g_async_rst
    always_ff @(posedge clk or posedge rst) begin
      if (rst)       r_sync <= '0;
      else if (i_en) r_sync <= {r_sync[0], i_d};
    end
  end else begin : g_sync_rst
    always_ff @(posedge clk) begin
      if (rst)       r_sync <= '0;
      else if (i_en) r_sync <= {r_sync[0], i_d};
    end
  end

  assign o_q = r_sync[1];
endmodule

// File: rtl/triple_flop_synchronizer.sv
// -----------------------------------------------------------------------------
// triple_flop_synchronizer
// Three-flop single-bit synchronizer with clock enable.
//   clk, rst        - destination clock, active-high reset
//   i_en            - clock enable; low holds all flops
//   i_d / o_q       - asynchronous input / synchronized output
// AT_POSEDGE_RST: nonzero selects asynchronous reset, zero synchronous reset.
// -----------------------------------------------------------------------------
module triple_flop_synchronizer #(
  parameter int unsigned AT_POSEDGE_RST = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_d,
  output logic o_q
);
  logic [2:0] r_sync;

  if (AT_POSEDGE_RST != 0) begin : g_async_rst
    always_ff @(posedge clk or posedge rst) begin
      if (rst)       r_sync <= '0;
      else if (i_en) r_sync <= {r_sync[1:0], i_d};
    end
  end else begin : g_sync_rst
    always_ff @(posedge clk) begin
      if (rst)       r_sync <= '0;
      else if (i_en) r_sync <= {r_sync[1:0], i_d};
    end
  end

  assign o_q = r_sync[2];
endmodule

// File: rtl/cdc_handshake_tx_controller.sv
// -----------------------------------------------------------------------------
// cdc_handshake_tx_controller
// Source-domain side of a four-phase req/ack handshake that carries a
// DATA_WIDTH-bit word into another clock domain. The word is latched on
// acceptance and held on xfer_data until the handshake completes.
// Ports:
//   clk, rst    - source clock, synchronous active-high reset
//   enable      - clock enable; low freezes FSM, ack synchronizer and counter
//   bus         - cdc_handshake_tx_controller_if.master (in_valid/in_ready/
//                 in_data, xfer_req/xfer_data/xfer_ack, busy/done/timeout_err)
// Parameters: DATA_WIDTH, SYNC_STAGES (2 or 3), TIMEOUT_CYCLES.
// Optional: define CDC_HANDSHAKE_TIMEOUT_EN to abort a phase that lasts
// TIMEOUT_CYCLES enabled cycles; otherwise timeout_err is tied 0.
// -----------------------------------------------------------------------------
module cdc_handshake_tx_controller
  import cdc_handshake_tx_controller_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic                          clk,
  input logic                          rst,
  input logic                          enable,
  cdc_handshake_tx_controller_if.master bus
);

  hs_state_e             r_state, w_state_nxt;
  logic                  r_xfer_req, w_xfer_req_nxt;
  logic [DATA_WIDTH-1:0] r_xfer_data, w_xfer_data_nxt;
  logic                  r_done, w_done_nxt;
  logic                  w_ack_s;
  logic                  w_in_ready;

  // Ack synchronizer: shares the controller's enable so a frozen block
  // does not advance the ack it later acts on.
  if (SYNC_STAGES == 3) begin : g_sync3
    triple_flop_synchronizer #(.AT_POSEDGE_RST(0)) u_ack_sync (
      .clk  (clk),
      .rst  (rst),
      .i_en (enable),
      .i_d  (bus.xfer_ack),
      .o_q  (w_ack_s)
    );
  end else begin : g_sync2
    double_flop_synchronizer #(.AT_POSEDGE_RST(0)) u_ack_sync (
      .clk  (clk),
      .rst  (rst),
      .i_en (enable),
      .i_d  (bus.xfer_ack),
      .o_q  (w_ack_s)
    );
  end

  // A stale ack left high (after reset or abort) blocks acceptance until it
  // falls, so the destination never sees a new req merged with an old ack.
  assign w_in_ready = (r_state == IDLE) && !w_ack_s && !rst;

`ifdef CDC_HANDSHAKE_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_timeout_err, w_timeout_err_nxt;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_xfer_req_nxt  = r_xfer_req;
    w_xfer_data_nxt = r_xfer_data;
    w_done_nxt      = 1'b0;
`ifdef CDC_HANDSHAKE_TIMEOUT_EN
    w_timeout_err_nxt = 1'b0;
    w_cnt_nxt         = '0;
`endif
    case (r_state)
      IDLE: begin
        if (bus.in_valid && w_in_ready) begin
          w_xfer_data_nxt = bus.in_data;
          w_xfer_req_nxt  = 1'b1;
          w_state_nxt     = REQ_HI;
        end
      end
      REQ_HI: begin
        if (w_ack_s) begin
          w_xfer_req_nxt = 1'b0;
          w_state_nxt    = REQ_LO;
        end
      end
      REQ_LO: begin
        if (!w_ack_s) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_xfer_req_nxt = 1'b0;
        w_state_nxt    = IDLE;
      end
    endcase
`ifdef CDC_HANDSHAKE_TIMEOUT_EN
    // Abort only when the phase did not complete this cycle, which keeps
    // done and timeout_err mutually exclusive.
    if ((r_state != IDLE) && (w_state_nxt == r_state) && (r_cnt == CNT_LAST)) begin
      w_xfer_req_nxt    = 1'b0;
      w_state_nxt       = IDLE;
      w_timeout_err_nxt = 1'b1;
    end
    if ((r_state != IDLE) && (w_state_nxt == r_state)) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_xfer_req  <= 1'b0;
      r_xfer_data <= '0;
      r_done      <= 1'b0;
`ifdef CDC_HANDSHAKE_TIMEOUT_EN
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
`endif
    end else if (enable) begin
      r_state     <= w_state_nxt;
      r_xfer_req  <= w_xfer_req_nxt;
      r_xfer_data <= w_xfer_data_nxt;
      r_done      <= w_done_nxt;
`ifdef CDC_HANDSHAKE_TIMEOUT_EN
      r_cnt         <= w_cnt_nxt;
      r_timeout_err <= w_timeout_err_nxt;
`endif
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.xfer_req  = r_xfer_req;
  assign bus.xfer_data = r_xfer_data;
  assign bus.busy      = (r_state != IDLE);
  assign bus.done      = r_done;
`ifdef CDC_HANDSHAKE_TIMEOUT_EN
  assign bus.timeout_err = r_timeout_err;
`else
  assign bus.timeout_err = 1'b0;
`endif

endmodule
